// File: rtl/axi4_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// axi4_sram_slave_pkg
// Shared definitions for the AXI4 SRAM slave:
//   - AXI burst type and response codes (same encodings the upstream bridge uses)
//   - FSM state encoding
//   - small helper mapping an error flag onto an AXI response code
// -----------------------------------------------------------------------------
package axi4_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDADDR,
        ST_RDATA
    } state_e;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_sram_slave_sram_bytewen.sv
// -----------------------------------------------------------------------------
// sram_bytewen
// Behavioural single-port RAM, 2^DEPTH_W words of DATA_W bits, per-byte write
// enables and a registered one-cycle read. Contents are never reset.
// Ports:
//   clk        clock
//   addr_i     word address shared by read and write
//   rd_en_i    capture mem[addr_i] into the read register
//   wr_be_i    per-byte write enables (all zero = no write)
//   wr_data_i  write data
//   rd_data_o  read data, holds its value until the next rd_en_i
// -----------------------------------------------------------------------------
module sram_bytewen #(
    parameter int DEPTH_W = 12,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic [DEPTH_W-1:0]    addr_i,
    input  logic                  rd_en_i,
    input  logic [DATA_W/8-1:0]   wr_be_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic [DATA_W-1:0]     rd_data_o
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**DEPTH_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_be_i[i]) begin
                mem_q[addr_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// axi4_sram_slave
// AXI4 slave in front of a byte-writable on-chip SRAM. One transaction at a
// time (no IDs, nothing outstanding); single beats and INCR/FIXED bursts.
// Reads run at one beat every two cycles (one-cycle SRAM latency, no prefetch).
// Build option:
//   AXI_SRAM_ERRCHK_EN  when defined, WRAP bursts, a beat size other than the
//                       full word, and misplaced wlast are reported as SLVERR.
//                       Bursts still run to len+1 beats and writes still land.
//                       When undefined, responses are always OKAY, WRAP acts
//                       as INCR and wlast is ignored.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   s_axi_aw*                  write address channel (lock/cache/prot/qos ignored)
//   s_axi_w*                   write data channel
//   s_axi_b*                   write response channel
//   s_axi_ar*                  read address channel (lock/cache/prot/qos ignored)
//   s_axi_r*                   read data channel
// -----------------------------------------------------------------------------
module axi4_sram_slave
    import axi4_sram_slave_pkg::*;
#(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 32,
    parameter int MEM_DEPTH_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int OFS = $clog2(AXI_DATA_W / 8);

    state_e                   state_q;
    logic [MEM_DEPTH_W-1:0]   idx_q;
    logic [7:0]               beat_q;
    logic [7:0]               len_q;
    logic                     incr_q;
    logic                     rvalid_q;
    logic                     rlast_q;
    logic [1:0]               bresp_q;
    logic [1:0]               rresp_q;

    logic [MEM_DEPTH_W-1:0]   aw_idx;
    logic [MEM_DEPTH_W-1:0]   ar_idx;
    logic                     aw_err;
    logic                     ar_err;
    logic                     wlast_err;
    logic                     ar_accept;
    logic                     final_beat;

    // Upper address bits alias onto the SRAM; byte-offset bits are dropped.
    assign aw_idx     = s_axi_awaddr[MEM_DEPTH_W+OFS-1:OFS];
    assign ar_idx     = s_axi_araddr[MEM_DEPTH_W+OFS-1:OFS];
    assign final_beat = (beat_q == len_q);

`ifdef AXI_SRAM_ERRCHK_EN
    assign aw_err    = (s_axi_awburst == BURST_WRAP) || (s_axi_awsize != 3'(OFS));
    assign ar_err    = (s_axi_arburst == BURST_WRAP) || (s_axi_arsize != 3'(OFS));
    assign wlast_err = (s_axi_wlast != final_beat);
`else
    assign aw_err    = 1'b0;
    assign ar_err    = 1'b0;
    assign wlast_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_arsize, s_axi_wlast,
                         s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // Write has priority: AR is only accepted in IDLE while no AW is offered.
    assign s_axi_awready = (state_q == ST_IDLE);
    assign s_axi_arready = (state_q == ST_IDLE) && !s_axi_awvalid;
    assign s_axi_wready  = (state_q == ST_WDATA);
    assign s_axi_bvalid  = (state_q == ST_WRESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign ar_accept     = s_axi_arready && s_axi_arvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            incr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    beat_q <= '0;
                    if (s_axi_awvalid) begin
                        idx_q   <= aw_idx;
                        len_q   <= s_axi_awlen;
                        incr_q  <= (s_axi_awburst != BURST_FIXED);
                        bresp_q <= resp_of(aw_err);
                        state_q <= ST_WDATA;
                    end else if (s_axi_arvalid) begin
                        // The SRAM read of the first word is issued this edge.
                        idx_q    <= ar_idx;
                        len_q    <= s_axi_arlen;
                        incr_q   <= (s_axi_arburst != BURST_FIXED);
                        rresp_q  <= resp_of(ar_err);
                        rvalid_q <= 1'b1;
                        rlast_q  <= (s_axi_arlen == 8'd0);
                        state_q  <= ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (s_axi_wvalid) begin
                        if (wlast_err) begin
                            bresp_q <= RESP_SLVERR;
                        end
                        if (incr_q) begin
                            idx_q <= idx_q + MEM_DEPTH_W'(1);
                        end
                        beat_q <= beat_q + 8'd1;
                        if (final_beat) begin
                            state_q <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (s_axi_bready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            if (incr_q) begin
                                idx_q <= idx_q + MEM_DEPTH_W'(1);
                            end
                            beat_q  <= beat_q + 8'd1;
                            state_q <= ST_RDADDR;
                        end
                    end
                end
                ST_RDADDR: begin
                    // Next word is read this edge; data is valid the cycle after.
                    rvalid_q <= 1'b1;
                    rlast_q  <= final_beat;
                    state_q  <= ST_RDATA;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // SRAM port: read address comes straight from AR while idle, otherwise
    // the burst index. Writes are suppressed on a reset edge so an in-flight
    // beat is dropped.
    logic [MEM_DEPTH_W-1:0]   ram_addr;
    logic                     ram_rd_en;
    logic [AXI_DATA_W/8-1:0]  ram_be;

    assign ram_addr  = (state_q == ST_IDLE) ? ar_idx : idx_q;
    assign ram_rd_en = ar_accept || (state_q == ST_RDADDR);
    assign ram_be    = (rst_n && (state_q == ST_WDATA) && s_axi_wvalid) ? s_axi_wstrb : '0;

    sram_bytewen #(
        .DEPTH_W (MEM_DEPTH_W),
        .DATA_W  (AXI_DATA_W)
    ) u_sram (
        .clk       (clk),
        .addr_i    (ram_addr),
        .rd_en_i   (ram_rd_en),
        .wr_be_i   (ram_be),
        .wr_data_i (s_axi_wdata),
        .rd_data_o (s_axi_rdata)
    );

endmodule

// File: tb/tb_axi4_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_sram_slave
// Self-checking bench for axi4_sram_slave (32-bit data, 4096-word SRAM).
// A word-array model tracks every write; reads push the model's expected beats
// onto a queue, which is popped as the DUT returns each R beat.
// -----------------------------------------------------------------------------
module tb_axi4_sram_slave;

`ifdef AXI_SRAM_ERRCHK_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam int         TMO   = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2;
    logic [1:0]  s_axi_awburst = INCR;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = INCR;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    always #5 clk = ~clk;

    axi4_sram_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awlock  (1'b0),
        .s_axi_awcache (4'h0),
        .s_axi_awprot  (3'h0),
        .s_axi_awqos   (4'h0),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arlock  (1'b0),
        .s_axi_arcache (4'h0),
        .s_axi_arprot  (3'h0),
        .s_axi_arqos   (4'h0),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_m [4096];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [11:0] idx, input logic [31:0] data, input logic [3:0] strb);
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) mem_m[idx][k*8 +: 8] = data[k*8 +: 8];
        end
    endtask

    // bad_last: beat index whose wlast is inverted (-1 = none)
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] d0,
                             input int bad_last, input logic [1:0] exp_resp);
        int          t;
        logic [11:0] idx;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < TMO) begin @(posedge clk); #1; t++; end
        check({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        idx = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata  = d0 + 32'(b);
            s_axi_wstrb  = strb;
            s_axi_wlast  = (b == int'(len)) ^ (b == bad_last);
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < TMO) begin @(posedge clk); #1; t++; end
            check({tag, "_wready"}, 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
            model_write(idx, d0 + 32'(b), strb);
            if (burst != FIXED) idx = idx + 12'd1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
        $display("WR %s addr=%h len=%0d burst=%0d bresp=%0d", tag, addr, len, burst, s_axi_bresp);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        check({tag, "_bdone"}, 32'(s_axi_bvalid), 32'd0);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int stall, input logic [1:0] exp_resp);
        int          t;
        logic [11:0] idx;
        logic [31:0] exp;
        idx = addr[13:2];
        for (int b = 0; b <= int'(len); b++) begin
            exp_q.push_back(mem_m[idx]);
            if (burst != FIXED) idx = idx + 12'd1;
        end
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < TMO) begin @(posedge clk); #1; t++; end
        check({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        check({tag, "_rlat"}, 32'(s_axi_rvalid), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!s_axi_rvalid && t < TMO) begin @(posedge clk); #1; t++; end
            check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    check({tag, "_hold"}, s_axi_rdata, exp_q[0]);
                    check({tag, "_holdv"}, 32'(s_axi_rvalid), 32'd1);
                    @(posedge clk); #1;
                end
            end
            exp = exp_q.pop_front();
            check({tag, "_rdata"}, s_axi_rdata, exp);
            check({tag, "_rlast"}, 32'(s_axi_rlast), 32'(b == int'(len)));
            check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
            $display("RD %s beat=%0d rdata=%h rlast=%0d rresp=%0d", tag, b, s_axi_rdata, s_axi_rlast, s_axi_rresp);
            s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_rready = 1'b0;
            if (b != int'(len)) check({tag, "_gap"}, 32'(s_axi_rvalid), 32'd0);
        end
        check({tag, "_rdone"}, 32'(s_axi_rvalid), 32'd0);
        check({tag, "_idle"}, 32'(s_axi_arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_awready", 32'(s_axi_awready), 32'd1);
        check("rst_arready", 32'(s_axi_arready), 32'd1);
        check("rst_wready",  32'(s_axi_wready),  32'd0);
        check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        check("rst_rlast",   32'(s_axi_rlast),   32'd0);
        check("rst_bresp",   32'(s_axi_bresp),   32'd0);
        check("rst_rresp",   32'(s_axi_rresp),   32'd0);

        // Single write, partial byte write, read-back of the merged word.
        axi_write("single", 32'h10, 8'd0, INCR, 4'hF, 32'hDEADBEEF, -1, 2'b00);
        axi_write("partial", 32'h10, 8'd0, INCR, 4'b0010, 32'h0000AA00, -1, 2'b00);
        check("partial_model", mem_m[4], 32'hDEADAAEF);
        axi_read("partial_rd", 32'h10, 8'd0, INCR, 0, 2'b00);
        // Upper address bits alias onto the same word.
        axi_read("alias_rd", 32'h4010, 8'd0, INCR, 0, 2'b00);

        // INCR burst of 1..4 and read-back; FIXED read with backpressure.
        axi_write("incr", 32'h100, 8'd3, INCR, 4'hF, 32'd1, -1, 2'b00);
        axi_read("incr_rd", 32'h100, 8'd3, INCR, 0, 2'b00);
        axi_read("fixed_rd", 32'h100, 8'd1, FIXED, 5, 2'b00);

        // FIXED write burst lands every beat on one word; index wraps at the top.
        axi_write("fixed_w", 32'h180, 8'd2, FIXED, 4'hF, 32'h0000_0A00, -1, 2'b00);
        axi_read("fixed_w_rd", 32'h180, 8'd0, INCR, 0, 2'b00);
        axi_write("wrapidx", 32'h3FFC, 8'd1, INCR, 4'hF, 32'hA000_0000, -1, 2'b00);
        axi_read("wrapidx_rd", 32'h3FFC, 8'd1, INCR, 0, 2'b00);

        // AW and AR together: write wins, read is taken right after B.
        s_axi_araddr  = 32'h20;
        s_axi_arlen   = 8'd0;
        s_axi_arburst = INCR;
        s_axi_arvalid = 1'b1;
        s_axi_awvalid = 1'b1;
        #1;
        check("both_arready", 32'(s_axi_arready), 32'd0);
        check("both_awready", 32'(s_axi_awready), 32'd1);
        axi_write("both_w", 32'h20, 8'd0, INCR, 4'hF, 32'h1234_5678, -1, 2'b00);
        axi_read("both_rd", 32'h20, 8'd0, INCR, 0, 2'b00);

        // Reset during the third beat of a burst: first two beats kept, rest dropped.
        axi_write("pre", 32'h200, 8'd3, INCR, 4'hF, 32'h50, -1, 2'b00);
        s_axi_awaddr  = 32'h200;
        s_axi_awlen   = 8'd3;
        s_axi_awburst = INCR;
        s_axi_awvalid = 1'b1;
        check("abort_awready", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_axi_wdata  = 32'h60 + 32'(b);
            s_axi_wstrb  = 4'hF;
            s_axi_wvalid = 1'b1;
            check("abort_wready", 32'(s_axi_wready), 32'd1);
            @(posedge clk); #1;
            model_write(12'h080 + 12'(b), 32'h60 + 32'(b), 4'hF);
        end
        s_axi_wdata = 32'h62;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_axi_wvalid = 1'b0;
        check("abort_idle", 32'(s_axi_awready), 32'd1);
        check("abort_wready0", 32'(s_axi_wready), 32'd0);
        bcnt = 0;
        s_axi_bready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (s_axi_bvalid) bcnt++;
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b0;
        check("abort_bvalid", 32'(bcnt), 32'd0);
        $display("RST abort after 2 beats, bvalid cycles=%0d", bcnt);
        axi_read("abort_rd", 32'h200, 8'd2, INCR, 0, 2'b00);

        // Protocol error reporting (OKAY when error checking is not built in).
        axi_write("wrap_w", 32'h300, 8'd1, WRAP, 4'hF, 32'h70, -1, ERR_RESP);
        axi_read("wrap_rd", 32'h300, 8'd1, WRAP, 0, ERR_RESP);
        axi_write("early_last", 32'h310, 8'd1, INCR, 4'hF, 32'h80, 0, ERR_RESP);
        axi_read("early_rd", 32'h310, 8'd1, INCR, 0, 2'b00);
        axi_write("ok_after", 32'h320, 8'd1, INCR, 4'hF, 32'h90, -1, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
